// File: rtl/data_sync_pkg.sv
// Shared constants and helpers for the multi-channel enable-qualified synchronizer.
// Latency: none (package only).
// Backpressure: none (package only).
package data_sync_pkg;

    // Qualifier interpretation per channel
    localparam logic MODE_LEVEL  = 1'b0;  // rising edge of the qualifier is an event
    localparam logic MODE_TOGGLE = 1'b1;  // any change of the qualifier is an event

    // Bit width needed to hold values 0..value-1, never narrower than one bit
    function automatic int clog2_min1(input int value);
        int r;
        r = $clog2(value);
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/data_sync_ch.sv
// One channel: qualifier sync chain, event detect, raw data capture, ack toggle, hold window, overrun flag.
// Latency: qualifier change first sampled at edge E1 -> sync_dat/enable_pulse update at edge E1+NUM_STAGES.
// Backpressure: none; the source must hold data until ack_tgl flips, events inside the hold window set ovf.
module data_sync_ch
    import data_sync_pkg::*;
#(
    parameter int   NUM_STAGES = 2,
    parameter int   BUS_WIDTH  = 8,
    parameter int   HOLD_CYC   = 4,
    parameter logic MODE       = MODE_LEVEL
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BUS_WIDTH-1:0] unsync_dat,
    input  logic                 enable,
    input  logic                 clr_ovf,
    output logic [BUS_WIDTH-1:0] sync_dat,
    output logic                 enable_pulse,
    output logic                 ack_tgl,
    output logic                 busy,
    output logic                 ovf
);

    // A chain shorter than two flops cannot both synchronize and compare old/new values
    if (NUM_STAGES < 2) begin : g_bad_stages
        $error("data_sync_ch: NUM_STAGES must be >= 2");
    end

    localparam int             CNT_W   = clog2_min1(HOLD_CYC + 1);
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYC);

    logic [NUM_STAGES-1:0] sync_q;   // sync_q[0] is the newest sample
    logic                  evt;
    logic                  evt_q;
    logic [CNT_W-1:0]      cnt;

    // Qualifier synchronizer chain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[NUM_STAGES-2:0], enable};
        end
    end

    // New-data event from the last two synchronized samples
    always_comb begin
        evt = 1'b0;
        if (MODE == MODE_TOGGLE) begin
            evt = sync_q[NUM_STAGES-2] ^ sync_q[NUM_STAGES-1];
        end else begin
            evt = sync_q[NUM_STAGES-2] & ~sync_q[NUM_STAGES-1];
        end
    end

    // Register the event so capture happens from a clean flop output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_q <= 1'b0;
        end else begin
            evt_q <= evt;
        end
    end

    // Capture raw data (already stable by the source contract), pulse and toggle ack
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_dat     <= '0;
            enable_pulse <= 1'b0;
            ack_tgl      <= 1'b0;
        end else if (evt_q) begin
            sync_dat     <= unsync_dat;
            enable_pulse <= 1'b1;
            ack_tgl      <= ~ack_tgl;
        end else begin
            enable_pulse <= 1'b0;
        end
    end

    // Hold window counter: reload on every capture, count down and stick at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (evt_q) begin
            cnt <= HOLD_LD;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign busy = (cnt != '0);

    // Sticky overrun: a capture inside the hold window sets it; set beats clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (evt_q && busy) begin
            ovf <= 1'b1;
        end else if (clr_ovf) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: rtl/data_sync_mc.sv
// Multi-channel enable-qualified synchronizer in the destination domain; channels are independent.
// Latency: qualifier change first sampled at edge E1 -> sync_bus/enable_pulse update at edge E1+NUM_STAGES.
// Backpressure: none; source waits for ack_tgl per channel, early events are flagged on ovf.
module data_sync_mc
    import data_sync_pkg::*;
#(
    parameter int              NUM_STAGES = 2,
    parameter int              BUS_WIDTH  = 8,
    parameter int              NUM_CH     = 4,
    parameter int              HOLD_CYC   = 4,
    parameter logic [NUM_CH-1:0] MODE_MASK = '0
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [NUM_CH*BUS_WIDTH-1:0] unsync_bus,
    input  logic [NUM_CH-1:0]           bus_enable,
    input  logic [NUM_CH-1:0]           clr_ovf,
    output logic [NUM_CH*BUS_WIDTH-1:0] sync_bus,
    output logic [NUM_CH-1:0]           enable_pulse,
    output logic [NUM_CH-1:0]           ack_tgl,
    output logic [NUM_CH-1:0]           busy,
    output logic [NUM_CH-1:0]           ovf
);

    // One channel instance per slice; no logic is shared between channels
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        data_sync_ch #(
            .NUM_STAGES (NUM_STAGES),
            .BUS_WIDTH  (BUS_WIDTH),
            .HOLD_CYC   (HOLD_CYC),
            .MODE       (MODE_MASK[i])
        ) u_ch (
            .clk          (CLK),
            .rst          (RST),
            .unsync_dat   (unsync_bus[i*BUS_WIDTH +: BUS_WIDTH]),
            .enable       (bus_enable[i]),
            .clr_ovf      (clr_ovf[i]),
            .sync_dat     (sync_bus[i*BUS_WIDTH +: BUS_WIDTH]),
            .enable_pulse (enable_pulse[i]),
            .ack_tgl      (ack_tgl[i]),
            .busy         (busy[i]),
            .ovf          (ovf[i])
        );
    end

endmodule

// File: tb/tb_data_sync_mc.sv
// Bench for data_sync_mc: directed tables, hand sequences and randomized traffic against a cycle-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_data_sync_mc;
    import data_sync_pkg::*;

    localparam int         N    = 2;
    localparam int         W    = 8;
    localparam int         NCH  = 4;
    localparam int         HOLD = 4;
    localparam logic [3:0] MASK = 4'b0010;
    localparam int         MAXC = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] unsync_bus = '0;
    logic [3:0]  bus_enable = '0;
    logic [3:0]  clr_ovf = '0;
    logic [31:0] sync_bus;
    logic [3:0]  enable_pulse, ack_tgl, busy, ovf;

    logic [15:0] ub2 = '0;
    logic        be2 = 1'b0;
    logic        clr2 = 1'b0;
    logic [15:0] sb2;
    logic        ep2, ack2, busy2, ovf2;

    always #5 clk = ~clk;

    data_sync_mc #(.NUM_STAGES(N), .BUS_WIDTH(W), .NUM_CH(NCH), .HOLD_CYC(HOLD), .MODE_MASK(MASK)) dut (
        .CLK(clk), .RST(rst), .unsync_bus(unsync_bus), .bus_enable(bus_enable), .clr_ovf(clr_ovf),
        .sync_bus(sync_bus), .enable_pulse(enable_pulse), .ack_tgl(ack_tgl), .busy(busy), .ovf(ovf));

    data_sync_mc #(.NUM_STAGES(3), .BUS_WIDTH(16), .NUM_CH(1), .HOLD_CYC(4), .MODE_MASK(1'b0)) dut2 (
        .CLK(clk), .RST(rst), .unsync_bus(ub2), .bus_enable(be2), .clr_ovf(clr2),
        .sync_bus(sb2), .enable_pulse(ep2), .ack_tgl(ack2), .busy(busy2), .ovf(ovf2));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // ---------------- reference model (event history per sampled edge) ----------------
    int         t = 0;
    bit         qh [NCH][MAXC];
    bit         rh [MAXC];
    logic [7:0] m_sync [NCH];
    bit         m_ack [NCH];
    bit         m_pulse [NCH];
    bit         m_ovf [NCH];
    int         m_last [NCH];
    logic [3:0] mask_v = MASK;

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_sync[c] = '0; m_ack[c] = 0; m_pulse[c] = 0; m_ovf[c] = 0; m_last[c] = -1000;
        end
    endtask

    task automatic model_edge();
        int e;
        bit ev, busy_before;
        t++;
        if (t >= MAXC) begin
            $display("FAIL model_history actual=%0d limit=%0d", t, MAXC);
            $fatal(1);
        end
        rh[t] = rst;
        for (int c = 0; c < NCH; c++) qh[c][t] = rst ? 1'b0 : bus_enable[c];
        if (rst) begin
            model_reset();
        end else begin
            for (int c = 0; c < NCH; c++) begin
                e  = t - N;   // edge at which a qualifier change captured now was first sampled
                ev = 0;
                if (e >= 1 && !rh[e]) begin
                    ev = mask_v[c] ? (qh[c][e] ^ qh[c][e-1]) : (qh[c][e] & ~qh[c][e-1]);
                    for (int k = e + 1; k <= t; k++) if (rh[k]) ev = 0;
                end
                busy_before = ((t - 1 - m_last[c]) < HOLD);
                m_pulse[c]  = ev;
                if (ev && busy_before) m_ovf[c] = 1;
                else if (clr_ovf[c])   m_ovf[c] = 0;
                if (ev) begin
                    m_sync[c] = unsync_bus[c*W +: W];
                    m_ack[c]  = ~m_ack[c];
                    m_last[c] = t;
                end
            end
        end
    endtask

    task automatic model_check();
        logic [31:0] es;
        logic [3:0]  ep, ea, eb, eo;
        for (int c = 0; c < NCH; c++) begin
            es[c*W +: W] = m_sync[c];
            ep[c] = m_pulse[c];
            ea[c] = m_ack[c];
            eb[c] = ((t - m_last[c]) < HOLD);
            eo[c] = m_ovf[c];
        end
        chk("model_sync_bus", sync_bus, es);
        chk("model_enable_pulse", {28'h0, enable_pulse}, {28'h0, ep});
        chk("model_ack_tgl", {28'h0, ack_tgl}, {28'h0, ea});
        chk("model_busy", {28'h0, busy}, {28'h0, eb});
        chk("model_ovf", {28'h0, ovf}, {28'h0, eo});
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        model_check();
    endtask

    // ---------------- directed vector tables ----------------
    typedef struct packed {
        logic        en;
        logic [15:0] dat;
        logic        pulse;
        logic [15:0] sync;
        logic        ack;
        logic        bsy;
    } vec_t;

    vec_t tab_a [8];
    vec_t tab_b [5];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] tv [3];
        logic [7:0] got [3];
        int         npulse;

        // level latency on ch0 (N=2): capture on third edge, data held afterwards
        tab_a[0] = '{1'b1, 16'h00A5, 1'b0, 16'h0000, 1'b0, 1'b0};
        tab_a[1] = '{1'b1, 16'h00A5, 1'b0, 16'h0000, 1'b0, 1'b0};
        tab_a[2] = '{1'b1, 16'h00A5, 1'b1, 16'h00A5, 1'b1, 1'b1};
        tab_a[3] = '{1'b1, 16'h003C, 1'b0, 16'h00A5, 1'b1, 1'b1};
        tab_a[4] = '{1'b0, 16'h003C, 1'b0, 16'h00A5, 1'b1, 1'b1};
        tab_a[5] = '{1'b0, 16'h003C, 1'b0, 16'h00A5, 1'b1, 1'b1};
        tab_a[6] = '{1'b0, 16'h003C, 1'b0, 16'h00A5, 1'b1, 1'b0};
        tab_a[7] = '{1'b0, 16'h003C, 1'b0, 16'h00A5, 1'b1, 1'b0};
        // three-stage, 16-bit single channel: capture on fourth edge
        tab_b[0] = '{1'b1, 16'hBEEF, 1'b0, 16'h0000, 1'b0, 1'b0};
        tab_b[1] = '{1'b1, 16'hBEEF, 1'b0, 16'h0000, 1'b0, 1'b0};
        tab_b[2] = '{1'b1, 16'hBEEF, 1'b0, 16'h0000, 1'b0, 1'b0};
        tab_b[3] = '{1'b1, 16'hBEEF, 1'b1, 16'hBEEF, 1'b1, 1'b1};
        tab_b[4] = '{1'b1, 16'h1234, 1'b0, 16'hBEEF, 1'b1, 1'b1};

        model_reset();
        #1;
        chk("reset_sync_bus", sync_bus, 32'h0);
        chk("reset_flags", {16'h0, enable_pulse, ack_tgl, busy, ovf}, 32'h0);
        repeat (3) cycle();
        rst = 1'b0;
        repeat (2) cycle();

        // reset while an event is in flight on ch0
        bus_enable[0] = 1'b1;
        unsync_bus[7:0] = 8'h55;
        cycle();
        rst = 1'b1;
        bus_enable[0] = 1'b0;
        #1;
        chk("rst_mid_outputs", {enable_pulse, ack_tgl, busy, ovf}, 32'h0);
        chk("rst_mid_sync", sync_bus, 32'h0);
        repeat (2) cycle();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("rst_no_pulse", {28'h0, enable_pulse}, 32'h0);
        end

        // table: level latency on ch0
        for (int i = 0; i < 8; i++) begin
            bus_enable[0]   = tab_a[i].en;
            unsync_bus[7:0] = tab_a[i].dat[7:0];
            cycle();
            chk("lvl_pulse", {31'h0, enable_pulse[0]}, {31'h0, tab_a[i].pulse});
            chk("lvl_sync", {24'h0, sync_bus[7:0]}, {24'h0, tab_a[i].sync[7:0]});
            chk("lvl_ack", {31'h0, ack_tgl[0]}, {31'h0, tab_a[i].ack});
            chk("lvl_busy", {31'h0, busy[0]}, {31'h0, tab_a[i].bsy});
        end

        // toggle mode on ch1: three toggles, three captures
        tv[0] = 8'h11; tv[1] = 8'h22; tv[2] = 8'h33;
        got[0] = '0; got[1] = '0; got[2] = '0;
        npulse = 0;
        for (int i = 0; i < 3; i++) begin
            unsync_bus[15:8] = tv[i];
            bus_enable[1]    = ~bus_enable[1];
            for (int k = 0; k < 8; k++) begin
                cycle();
                if (enable_pulse[1]) begin
                    if (npulse < 3) got[npulse] = sync_bus[15:8];
                    npulse++;
                end
            end
        end
        chk("tgl_pulse_count", npulse, 3);
        for (int i = 0; i < 3; i++) chk("tgl_data", {24'h0, got[i]}, {24'h0, tv[i]});
        chk("tgl_ack_end", {31'h0, ack_tgl[1]}, 32'h1);
        bus_enable[1] = 1'b0;
        repeat (8) cycle();

        // overrun on ch2: two captures two cycles apart
        unsync_bus[23:16] = 8'hAA;
        bus_enable[2] = 1'b1; cycle();
        bus_enable[2] = 1'b0; cycle();
        bus_enable[2] = 1'b1; cycle();
        chk("ovr_first_data", {24'h0, sync_bus[23:16]}, 32'hAA);
        chk("ovr_first_ovf", {31'h0, ovf[2]}, 32'h0);
        bus_enable[2] = 1'b0;
        unsync_bus[23:16] = 8'hBB;
        cycle();
        cycle();
        chk("ovr_pulse", {31'h0, enable_pulse[2]}, 32'h1);
        chk("ovr_set", {31'h0, ovf[2]}, 32'h1);
        chk("ovr_latest_data", {24'h0, sync_bus[23:16]}, 32'hBB);
        for (int k = 0; k < 4; k++) begin
            chk("ovr_busy_held", {31'h0, busy[2]}, 32'h1);
            cycle();
        end
        chk("ovr_busy_done", {31'h0, busy[2]}, 32'h0);
        chk("ovr_sticky", {31'h0, ovf[2]}, 32'h1);
        clr_ovf[2] = 1'b1;
        cycle();
        clr_ovf[2] = 1'b0;
        chk("ovr_cleared", {31'h0, ovf[2]}, 32'h0);

        // all channels fire on the same edge
        bus_enable = 4'h0;
        repeat (6) cycle();
        unsync_bus = 32'h04030201;
        bus_enable = 4'hF;
        repeat (2) cycle();
        chk("conc_early", {28'h0, enable_pulse}, 32'h0);
        cycle();
        chk("conc_pulse", {28'h0, enable_pulse}, 32'hF);
        chk("conc_data", sync_bus, 32'h04030201);
        cycle();
        chk("conc_pulse_one", {28'h0, enable_pulse}, 32'h0);

        // table: three-stage, 16-bit instance
        for (int i = 0; i < 5; i++) begin
            be2 = tab_b[i].en;
            ub2 = tab_b[i].dat;
            cycle();
            chk("swp_pulse", {31'h0, ep2}, {31'h0, tab_b[i].pulse});
            chk("swp_sync", {16'h0, sb2}, {16'h0, tab_b[i].sync});
            chk("swp_ack", {31'h0, ack2}, {31'h0, tab_b[i].ack});
            chk("swp_busy", {31'h0, busy2}, {31'h0, tab_b[i].bsy});
        end
        chk("swp_ovf", {31'h0, ovf2}, 32'h0);

        // randomized traffic, including a reset burst and clear/overrun collisions
        for (int i = 0; i < 800; i++) begin
            for (int c = 0; c < NCH; c++)
                if ($urandom_range(3) == 0) bus_enable[c] = ~bus_enable[c];
            if ($urandom_range(2) == 0) unsync_bus = $urandom;
            clr_ovf = ($urandom_range(5) == 0) ? 4'($urandom) : 4'h0;
            rst = (i >= 400 && i < 402);
            cycle();
        end
        rst = 1'b0;
        clr_ovf = '0;
        repeat (4) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
